// File: rtl/ram_ws_mem.sv
// ram_ws_mem: word-addressed RAM for the core's mem_* port, byte write masks,
// optional wait states with busy handshake, and out-of-range error pulse.
//
// Ports:
//   clk        clock, all state updates on posedge
//   resetn     asynchronous active-low reset
//   mem_addr   byte address; word index = mem_addr[31:2]
//   mem_rstrb  read request pulse
//   mem_wdata  write data, byte lanes aligned to mem_wmask
//   mem_wmask  byte write enables; any bit set = write request
//   mem_rdata  read data, held until the next read completes
//   mem_rbusy  read in progress
//   mem_wbusy  write in progress
//   mem_err    one-cycle pulse after an out-of-range access completes
//
// WAIT_STATES=0 completes the access on the accept edge (legacy timing).
// WAIT_STATES=N>0 holds the access in WAIT for N cycles, completing on the
// edge where the down-counter reads 1.
module ram_ws_mem #(
    parameter int    DEPTH_WORDS = 256,
    parameter int    WAIT_STATES = 0,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] mem_addr,
    input  logic        mem_rstrb,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    output logic [31:0] mem_rdata,
    output logic        mem_rbusy,
    output logic        mem_wbusy,
    output logic        mem_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    logic [31:0] mem [DEPTH_WORDS];

    state_t      state, state_nxt;
    logic [2:0]  cnt;

    // Request captured at accept; only consumed when WAIT_STATES > 0.
    logic [29:0] idx_q;
    logic [31:0] wdata_q;
    logic [3:0]  wmask_q;
    logic        rd_q;

    logic        req, accept, done;
    logic [29:0] c_idx;
    logic [31:0] c_wdata;
    logic [3:0]  c_wmask;
    logic        c_rd;
    logic        in_range;
    logic [AW-1:0] widx;

    // Byte-offset bits have no meaning for a word RAM.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^mem_addr[1:0];

    assign req = mem_rstrb | (|mem_wmask);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    accept = 1'b1;
                    if (WAIT_STATES == 0) done = 1'b1;
                    else                  state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == 3'd1) begin
                    done      = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Zero wait states complete on the live bus; otherwise on the latched copy.
    assign c_idx   = (WAIT_STATES == 0) ? mem_addr[31:2] : idx_q;
    assign c_wdata = (WAIT_STATES == 0) ? mem_wdata      : wdata_q;
    assign c_wmask = (WAIT_STATES == 0) ? mem_wmask      : wmask_q;
    assign c_rd    = (WAIT_STATES == 0) ? mem_rstrb      : rd_q;

    // Full-width compare: indices beyond the array never alias onto it.
    assign in_range = ({2'b00, c_idx} < 32'(DEPTH_WORDS));
    assign widx     = c_idx[AW-1:0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= S_IDLE;
            cnt       <= 3'd0;
            idx_q     <= 30'd0;
            wdata_q   <= 32'd0;
            wmask_q   <= 4'd0;
            rd_q      <= 1'b0;
            mem_rdata <= 32'd0;
            mem_rbusy <= 1'b0;
            mem_wbusy <= 1'b0;
            mem_err   <= 1'b0;
        end else begin
            state   <= state_nxt;
            mem_err <= done & ~in_range;

            if (accept) begin
                idx_q   <= mem_addr[31:2];
                wdata_q <= mem_wdata;
                wmask_q <= mem_wmask;
                rd_q    <= mem_rstrb;
                if (WAIT_STATES != 0) begin
                    cnt       <= 3'(WAIT_STATES);
                    mem_rbusy <= mem_rstrb;
                    mem_wbusy <= |mem_wmask;
                end
            end else if (state == S_WAIT) begin
                cnt <= cnt - 3'd1;
            end

            if (done) begin
                mem_rbusy <= 1'b0;
                mem_wbusy <= 1'b0;
                // Same-edge read sees the pre-write word.
                if (c_rd) mem_rdata <= in_range ? mem[widx] : 32'd0;
            end
        end
    end

    // resetn gate: a request sitting on the bus during reset must not commit.
    always_ff @(posedge clk) begin
        if (resetn && done && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (c_wmask[b]) mem[widx][8*b +: 8] <= c_wdata[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ram_ws_mem.sv
// Directed bench for ram_ws_mem. Four instances with different wait-state
// counts share clock, reset, address and write data; each has its own
// request strobes. Index 0: WS=0, 1: WS=3, 2: WS=2, 3: WS=4.
module tb_ram_ws_mem;

    logic        clk;
    logic        resetn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  rstrb;
    logic [3:0]  wmask [4];
    logic [31:0] rdata [4];
    logic [3:0]  rbusy, wbusy, err;

    int checks = 0;
    int fails  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        ram_ws_mem #(
            .DEPTH_WORDS(256),
            .WAIT_STATES(g == 0 ? 0 : g == 1 ? 3 : g == 2 ? 2 : 4),
            .INIT_FILE  ("")
        ) u_dut (
            .clk      (clk),
            .resetn   (resetn),
            .mem_addr (addr),
            .mem_rstrb(rstrb[g]),
            .mem_wdata(wdata),
            .mem_wmask(wmask[g]),
            .mem_rdata(rdata[g]),
            .mem_rbusy(rbusy[g]),
            .mem_wbusy(wbusy[g]),
            .mem_err  (err[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the first negedge with both busy low.
    task automatic wait_idle(input int i);
        bit ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (!rbusy[i] && !wbusy[i]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) chk("busy_timeout", 32'd1, 32'd0);
    endtask

    task automatic wr(input int i, input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        addr = a; wdata = d; wmask[i] = m;
        @(negedge clk);
        wmask[i] = 4'h0;
        wait_idle(i);
    endtask

    task automatic rd(input int i, input logic [31:0] a);
        addr = a; rstrb[i] = 1'b1;
        @(negedge clk);
        rstrb[i] = 1'b0;
        wait_idle(i);
    endtask

    initial begin
        resetn = 1'b0; addr = '0; wdata = '0; rstrb = '0;
        for (int i = 0; i < 4; i++) wmask[i] = 4'h0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk("rst_rdata", rdata[i], 32'd0);
            chk("rst_flags", {29'd0, rbusy[i], wbusy[i], err[i]}, 32'd0);
        end
        resetn = 1'b1;
        @(negedge clk);

        // 1: WS=0 full-word write then read, no busy
        addr = 32'h10; wdata = 32'hDEADBEEF; wmask[0] = 4'hF;
        @(negedge clk);
        wmask[0] = 4'h0;
        chk("t1_wbusy", {31'd0, wbusy[0]}, 32'd0);
        chk("t1_err", {31'd0, err[0]}, 32'd0);
        rstrb[0] = 1'b1;
        @(negedge clk);
        rstrb[0] = 1'b0;
        chk("t1_rdata", rdata[0], 32'hDEADBEEF);
        chk("t1_rbusy", {31'd0, rbusy[0]}, 32'd0);

        // 2: WS=0 byte-mask merges
        wr(0, 32'h20, 32'h11223344, 4'hF);
        wr(0, 32'h20, 32'h000000AA, 4'b0001);
        wr(0, 32'h20, 32'h00BB0000, 4'b0100);
        chk("t2_hold", rdata[0], 32'hDEADBEEF);
        rd(0, 32'h20);
        chk("t2_merge", rdata[0], 32'h11BB33AA);

        // 4: WS=0 range boundaries
        wr(0, 32'h0, 32'hA5A5A5A5, 4'hF);
        wr(0, 32'h3FC, 32'h0F0F1234, 4'hF);
        chk("t4_last_noerr", {31'd0, err[0]}, 32'd0);
        rd(0, 32'h3FC);
        chk("t4_last_rd", rdata[0], 32'h0F0F1234);
        addr = 32'h400; wdata = 32'h55; wmask[0] = 4'hF;
        @(negedge clk);
        wmask[0] = 4'h0;
        chk("t4_err_pulse", {31'd0, err[0]}, 32'd1);
        @(negedge clk);
        chk("t4_err_end", {31'd0, err[0]}, 32'd0);
        rd(0, 32'h400);
        chk("t4_oor_rd", rdata[0], 32'd0);
        chk("t4_oor_rd_err", {31'd0, err[0]}, 32'd1);
        rd(0, 32'h0);
        chk("t4_word0", rdata[0], 32'hA5A5A5A5);

        // 3: WS=3 read timing, request during wait ignored
        wr(1, 32'h194, 32'h11111111, 4'hF);
        addr = 32'h190; wdata = 32'h0BADC0DE; wmask[1] = 4'hF;
        @(negedge clk);
        wmask[1] = 4'h0;
        chk("t3_wbusy", {31'd0, wbusy[1]}, 32'd1);
        wait_idle(1);
        rstrb[1] = 1'b1; addr = 32'h190;
        @(negedge clk);
        rstrb[1] = 1'b0;
        chk("t3_rbusy1", {31'd0, rbusy[1]}, 32'd1);
        @(negedge clk);
        chk("t3_rbusy2", {31'd0, rbusy[1]}, 32'd1);
        rstrb[1] = 1'b1; addr = 32'h194;
        @(negedge clk);
        rstrb[1] = 1'b0;
        chk("t3_rbusy3", {31'd0, rbusy[1]}, 32'd1);
        chk("t3_rdata_hold", rdata[1], 32'd0);
        @(negedge clk);
        chk("t3_rbusy4", {31'd0, rbusy[1]}, 32'd0);
        chk("t3_rdata", rdata[1], 32'h0BADC0DE);
        @(negedge clk);
        chk("t3_ignored", {31'd0, rbusy[1]}, 32'd0);
        chk("t3_rdata_keep", rdata[1], 32'h0BADC0DE);

        // 5: WS=2 read-before-write
        wr(2, 32'h40, 32'h12345678, 4'hF);
        addr = 32'h40; wdata = 32'hCAFEF00D; wmask[2] = 4'hF; rstrb[2] = 1'b1;
        @(negedge clk);
        wmask[2] = 4'h0; rstrb[2] = 1'b0;
        chk("t5_busy1", {30'd0, rbusy[2], wbusy[2]}, 32'd3);
        @(negedge clk);
        chk("t5_busy2", {30'd0, rbusy[2], wbusy[2]}, 32'd3);
        @(negedge clk);
        chk("t5_busy3", {30'd0, rbusy[2], wbusy[2]}, 32'd0);
        chk("t5_rbw", rdata[2], 32'h12345678);
        rd(2, 32'h40);
        chk("t5_after", rdata[2], 32'hCAFEF00D);

        // 6: WS=4 reset mid-wait discards the write
        wr(3, 32'h80, 32'h600DF00D, 4'hF);
        addr = 32'h80; wdata = 32'hBAD0BAD0; wmask[3] = 4'hF;
        @(negedge clk);
        wmask[3] = 4'h0;
        @(negedge clk);
        chk("t6_wbusy", {31'd0, wbusy[3]}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("t6_async", {31'd0, wbusy[3]}, 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("t6_idle", {31'd0, wbusy[3]}, 32'd0);
        rd(3, 32'h80);
        chk("t6_word", rdata[3], 32'h600DF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
